// File: rtl/rr_mux2_pkg.sv
// Shared constants and types for the round-robin 2:1 stream merger.
// Source encoding matches mux21 (0 = in0, 1 = in1).
package rr_mux2_pkg;

  localparam logic SEL_IN0  = 1'b0;
  localparam logic SEL_IN1  = 1'b1;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  // Output stage state: EMPTY means out_valid=0, FULL means out_valid=1.
  typedef enum logic {
    STATE_EMPTY = ST_EMPTY,
    STATE_FULL  = ST_FULL
  } state_t;

  // Turn a source index into its one-hot grant vector.
  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return (idx == SEL_IN1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin arbiter.
// With both requests active the input that did not win last time is granted.
// gnt is one-hot, or zero when en is low or nobody requests.
module rr_arb2
  import rr_mux2_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  // Pick the winner index, then qualify it into a one-hot grant.
  always_comb begin
    gnt_idx = SEL_IN0;
    case (req)
      2'b01:   gnt_idx = SEL_IN0;
      2'b10:   gnt_idx = SEL_IN1;
      2'b11:   gnt_idx = ~last_gnt;
      default: gnt_idx = SEL_IN0;
    endcase
    gnt = (en && (req != 2'b00)) ? idx_to_onehot(gnt_idx) : 2'b00;
  end

endmodule

// File: rtl/rr_mux2_stream.sv
// Round-robin merge of two valid/ready streams into one registered output.
// The output stage accepts a new word whenever it is empty or being drained
// this cycle, so back-to-back transfers run at one word per clock.
// Optional feature macro: RR_MUX2_STATS_EN adds per-input grant counters
// (gnt0_cnt / gnt1_cnt, parameter CNT_W).
module rr_mux2_stream
  import rr_mux2_pkg::*;
#(
  parameter int W = 8
`ifdef RR_MUX2_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [W-1:0]     in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [W-1:0]     in1_data,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic             out_sel,
  input  logic             out_ready
`ifdef RR_MUX2_STATS_EN
  ,
  output logic [CNT_W-1:0] gnt0_cnt,
  output logic [CNT_W-1:0] gnt1_cnt
`endif
);

  state_t         state_reg;
  logic [W-1:0]   data_reg;
  logic           sel_reg;
  logic           last_gnt_reg;

  logic           load;
  logic [1:0]     gnt;
  logic           gnt_idx;
  logic           grant_any;
  logic [W-1:0]   mux_data;

  // The output register can take a word when empty or when its word leaves now.
  assign load = (state_reg == STATE_EMPTY) || out_ready;

  rr_arb2 u_arb (
    .req      ({in1_valid, in0_valid}),
    .last_gnt (last_gnt_reg),
    .en       (load),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx)
  );

  assign grant_any = |gnt;
  assign in0_ready = gnt[0];
  assign in1_ready = gnt[1];

  // mux21 data path: s = gnt_idx picks in1 when high.
  assign mux_data = (gnt_idx == SEL_IN1) ? in1_data : in0_data;

  // Output stage FSM: capture the granted word, drain when nothing new arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= STATE_EMPTY;
      data_reg     <= '0;
      sel_reg      <= SEL_IN0;
      last_gnt_reg <= SEL_IN1;
    end else begin
      case (state_reg)
        STATE_EMPTY: begin
          if (grant_any) begin
            state_reg    <= STATE_FULL;
            data_reg     <= mux_data;
            sel_reg      <= gnt_idx;
            last_gnt_reg <= gnt_idx;
          end
        end
        STATE_FULL: begin
          if (out_ready) begin
            if (grant_any) begin
              data_reg     <= mux_data;
              sel_reg      <= gnt_idx;
              last_gnt_reg <= gnt_idx;
            end else begin
              state_reg <= STATE_EMPTY;
            end
          end
        end
        default: state_reg <= STATE_EMPTY;
      endcase
    end
  end

  assign out_valid = (state_reg == STATE_FULL);
  assign out_data  = data_reg;
  assign out_sel   = sel_reg;

`ifdef RR_MUX2_STATS_EN
  logic [CNT_W-1:0] cnt0_reg;
  logic [CNT_W-1:0] cnt1_reg;

  // Count accepted words per input; counters wrap and clear only on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_reg <= '0;
      cnt1_reg <= '0;
    end else begin
      if (gnt[0]) cnt0_reg <= cnt0_reg + CNT_W'(1);
      if (gnt[1]) cnt1_reg <= cnt1_reg + CNT_W'(1);
    end
  end

  assign gnt0_cnt = cnt0_reg;
  assign gnt1_cnt = cnt1_reg;
`endif

endmodule
